// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

   localparam int DEF_PC_W     = 16;
   localparam int DEF_INST_W   = 32;
   localparam int DEF_IMM_W    = 64;
   localparam int DEF_RESET_PC = 0;
   localparam int PC_STEP      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic                 valid;
      logic                 taken;
      logic [DEF_PC_W-1:0]  pc;
      logic [DEF_IMM_W-1:0] imm;
   } br_res_t;

endpackage

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - branch target: pc + (imm << 1), wrapped and word aligned
module branch_target_calc
   import fetch_pkg::*;
#(
   parameter int PC_W  = DEF_PC_W,
   parameter int IMM_W = DEF_IMM_W
) (
   input  logic [PC_W-1:0]  pc_i,
   input  logic [IMM_W-1:0] imm_i,
   output logic [PC_W-1:0]  target_o
);

   logic [PC_W-1:0] sum;
   logic            unused_imm_hi;

   // Upper immediate bits are pure sign extension; only the low PC_W bits matter after wrap.
   assign unused_imm_hi = ^imm_i[IMM_W-1:PC_W];
   assign sum           = pc_i + (imm_i[PC_W-1:0] << 1);
   assign target_o      = sum & ~PC_W'(3);

endmodule

// File: rtl/branch_fetch_unit.sv
// rtl/branch_fetch_unit.sv - PC sequencer and single-outstanding fetch; FETCH_REDIRECT_COUNT_EN adds redirect_cnt
module branch_fetch_unit
   import fetch_pkg::*;
#(
   parameter int PC_W     = DEF_PC_W,
   parameter int INST_W   = DEF_INST_W,
   parameter int IMM_W    = DEF_IMM_W,
   parameter int RESET_PC = DEF_RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst,
   output logic [PC_W-1:0]   inst_pc,
   input  logic              br_valid,
   input  logic              br_taken,
   input  logic [PC_W-1:0]   br_pc,
   input  logic [IMM_W-1:0]  br_imm,
`ifdef FETCH_REDIRECT_COUNT_EN
   output logic [15:0]       redirect_cnt,
`endif
   output logic              redirect
);

   fetch_state_e      state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
   logic              discard_q, discard_d;
   logic              redirect_q, redirect_d;
   logic              take;
   logic [PC_W-1:0]   target;
   br_res_t           br;

   assign br = '{valid: br_valid, taken: br_taken,
                 pc: DEF_PC_W'(br_pc), imm: DEF_IMM_W'(br_imm)};

   branch_target_calc #(.PC_W(PC_W), .IMM_W(IMM_W)) u_target (
      .pc_i     (PC_W'(br.pc)),
      .imm_i    (IMM_W'(br.imm)),
      .target_o (target)
   );

   assign take = br.valid & br.taken & (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      discard_d  = discard_q;
      redirect_d = 1'b0;
      unique case (state_q)
         IDLE: state_d = REQ;
         REQ:  if (imem_req_ready) state_d = WAIT;
         WAIT: if (imem_rsp_valid) begin
            if (discard_q) begin
               discard_d = 1'b0;
               state_d   = REQ;
            end else begin
               inst_d    = imem_rsp_data;
               inst_pc_d = pc_q;
               state_d   = HOLD;
            end
         end
         HOLD: if (inst_ready) begin
            pc_d    = pc_q + PC_W'(PC_STEP);
            state_d = REQ;
         end
         default: state_d = IDLE;
      endcase

      // A taken branch overrides everything above; an issued request becomes a stale response to drop.
      if (take) begin
         pc_d       = target;
         redirect_d = 1'b1;
         inst_d     = inst_q;
         inst_pc_d  = inst_pc_q;
         unique case (state_q)
            REQ: begin
               state_d   = imem_req_ready ? WAIT : REQ;
               discard_d = imem_req_ready;
            end
            WAIT: begin
               state_d   = imem_rsp_valid ? REQ : WAIT;
               discard_d = ~imem_rsp_valid;
            end
            default: state_d = REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= PC_W'(RESET_PC);
         inst_q     <= '0;
         inst_pc_q  <= '0;
         discard_q  <= 1'b0;
         redirect_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         inst_pc_q  <= inst_pc_d;
         discard_q  <= discard_d;
         redirect_q <= redirect_d;
      end
   end

`ifdef FETCH_REDIRECT_COUNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (redirect_d && cnt_q != 16'hFFFF) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign redirect_cnt = cnt_q;
`endif

   assign imem_req_valid = (state_q == REQ);
   assign imem_addr      = pc_q;
   assign inst_valid     = (state_q == HOLD);
   assign inst           = inst_q;
   assign inst_pc        = inst_pc_q;
   assign redirect       = redirect_q;

endmodule

// File: tb/tb_branch_fetch_unit.sv
// tb/tb_branch_fetch_unit.sv - directed self-checking bench for branch_fetch_unit
module tb_branch_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [15:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [15:0] inst_pc;
   logic        br_valid;
   logic        br_taken;
   logic [15:0] br_pc;
   logic [63:0] br_imm;
   logic        redirect;
`ifdef FETCH_REDIRECT_COUNT_EN
   logic [15:0] redirect_cnt;
`endif

   int compared = 0;
   int mismatched = 0;
   int redirect_pulses = 0;

   logic        auto_rsp;
   logic        man_rsp;
   logic        rsp_pend;
   logic [15:0] rsp_addr_q;

   always #5 clk = ~clk;

   branch_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .br_valid       (br_valid),
      .br_taken       (br_taken),
      .br_pc          (br_pc),
      .br_imm         (br_imm),
`ifdef FETCH_REDIRECT_COUNT_EN
      .redirect_cnt   (redirect_cnt),
`endif
      .redirect       (redirect)
   );

   // Memory answers one cycle after the handshake with a word tagged by its address.
   always @(posedge clk) begin
      if (rst) begin
         rsp_pend <= 1'b0;
      end else begin
         rsp_pend <= imem_req_valid & imem_req_ready;
         if (imem_req_valid & imem_req_ready) rsp_addr_q <= imem_addr;
      end
   end
   assign imem_rsp_valid = (rsp_pend & auto_rsp) | man_rsp;
   assign imem_rsp_data  = {16'hC0DE, rsp_addr_q};

   task automatic tick();
      @(posedge clk);
      #1;
      if (redirect) redirect_pulses++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic branch(input logic taken, input logic [15:0] pc, input logic [63:0] imm);
      br_valid = 1'b1;
      br_taken = taken;
      br_pc    = pc;
      br_imm   = imm;
   endtask

   task automatic br_clear();
      br_valid = 1'b0;
      br_taken = 1'b0;
   endtask

   initial begin
      logic [31:0] held_inst;
      int          unstable;
      rst = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
      br_valid = 1'b0; br_taken = 1'b0; br_pc = '0; br_imm = '0;
      auto_rsp = 1'b1; man_rsp = 1'b0; rsp_addr_q = '0;

      tick(); tick();
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", 32'(inst_pc), 32'd0);
      chk("rst_redirect", 32'(redirect), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      redirect_pulses = 0;

      rst = 1'b0;
      tick();
      chk("seq0_req", 32'(imem_req_valid), 32'd1);
      chk("seq0_addr", 32'(imem_addr), 32'd0);
      tick(); tick();
      chk("seq0_hold", 32'(inst_valid), 32'd1);
      chk("seq0_inst", inst, 32'hC0DE_0000);
      tick();
      chk("seq1_req", 32'(imem_req_valid), 32'd1);
      chk("seq1_addr", 32'(imem_addr), 32'd4);
      tick(); tick(); tick();
      chk("seq2_req", 32'(imem_req_valid), 32'd1);
      chk("seq2_addr", 32'(imem_addr), 32'd8);
      tick(); tick(); tick();
      chk("seq3_req", 32'(imem_req_valid), 32'd1);
      chk("seq3_addr", 32'(imem_addr), 32'd12);
      chk("seq_no_redirect", 32'(redirect_pulses), 32'd0);

      tick();
      inst_ready = 1'b0;
      tick();
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst", inst, 32'hC0DE_000C);
      chk("stall_pc", 32'(inst_pc), 32'd12);
      held_inst = inst;
      unstable = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (!inst_valid || inst !== held_inst || inst_pc !== 16'd12 || imem_req_valid) unstable++;
      end
      chk("stall_stable", 32'(unstable), 32'd0);
      inst_ready = 1'b1;
      tick();
      chk("stall_release_addr", 32'(imem_addr), 32'd16);
      chk("stall_release_req", 32'(imem_req_valid), 32'd1);

      inst_ready = 1'b0;
      tick(); tick();
      chk("hold16_pc", 32'(inst_pc), 32'd16);
      branch(1'b1, 16'd8, 64'd6);
      tick();
      br_clear();
      chk("br_hold_redirect", 32'(redirect), 32'd1);
      chk("br_hold_inst_valid", 32'(inst_valid), 32'd0);
      chk("br_hold_addr", 32'(imem_addr), 32'd20);
      chk("br_hold_req", 32'(imem_req_valid), 32'd1);
      tick();
      chk("br_pulse_one_cycle", 32'(redirect), 32'd0);
      tick();
      chk("hold20_pc", 32'(inst_pc), 32'd20);

      branch(1'b0, 16'd8, 64'd6);
      tick();
      br_clear();
      chk("nt_redirect", 32'(redirect), 32'd0);
      chk("nt_inst_valid", 32'(inst_valid), 32'd1);
      chk("nt_inst_pc", 32'(inst_pc), 32'd20);

      branch(1'b1, 16'hFFF0, 64'd16);
      tick();
      br_clear();
      chk("wrap_addr", 32'(imem_addr), 32'h0010);
      chk("wrap_redirect", 32'(redirect), 32'd1);
      tick(); tick();
      chk("hold10_pc", 32'(inst_pc), 32'h0010);
      branch(1'b1, 16'd8, 64'hFFFF_FFFF_FFFF_FFFE);
      tick();
      br_clear();
      chk("neg_imm_addr", 32'(imem_addr), 32'd4);

      auto_rsp = 1'b0;
      tick();
      chk("wait_state_req", 32'(imem_req_valid), 32'd0);
      branch(1'b1, 16'h0040, 64'd4);
      tick();
      br_clear();
      chk("br_wait_redirect", 32'(redirect), 32'd1);
      chk("br_wait_still_waiting", 32'(imem_req_valid), 32'd0);
      tick();
      man_rsp = 1'b1;
      tick();
      man_rsp = 1'b0;
      chk("br_wait_dropped", 32'(inst_valid), 32'd0);
      chk("br_wait_req", 32'(imem_req_valid), 32'd1);
      chk("br_wait_addr", 32'(imem_addr), 32'h0048);
      auto_rsp = 1'b1;
      tick(); tick();
      chk("hold48_inst", inst, 32'hC0DE_0048);
      chk("hold48_pc", 32'(inst_pc), 32'h0048);

      inst_ready = 1'b1;
      tick();
      chk("req4c_addr", 32'(imem_addr), 32'h004C);
      branch(1'b1, 16'h0100, 64'd0);
      tick();
      br_clear();
      chk("br_req_hs_wait", 32'(imem_req_valid), 32'd0);
      chk("br_req_hs_redirect", 32'(redirect), 32'd1);
      tick();
      chk("br_req_hs_dropped", 32'(inst_valid), 32'd0);
      chk("br_req_hs_addr", 32'(imem_addr), 32'h0100);
      chk("br_req_hs_req", 32'(imem_req_valid), 32'd1);
`ifdef FETCH_REDIRECT_COUNT_EN
      chk("cnt_after_5", 32'(redirect_cnt), 32'd5);
`endif

      tick();
      rst = 1'b1;
      tick();
      chk("midrst_req", 32'(imem_req_valid), 32'd0);
      chk("midrst_addr", 32'(imem_addr), 32'd0);
      chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
`ifdef FETCH_REDIRECT_COUNT_EN
      chk("midrst_cnt", 32'(redirect_cnt), 32'd0);
`endif
      rst = 1'b0;
      man_rsp = 1'b1;
      tick();
      man_rsp = 1'b0;
      chk("late_rsp_ignored", 32'(inst_valid), 32'd0);
      chk("post_rst_addr", 32'(imem_addr), 32'd0);
      chk("post_rst_req", 32'(imem_req_valid), 32'd1);
      tick(); tick();
      chk("post_rst_inst", inst, 32'hC0DE_0000);
      chk("post_rst_inst_pc", 32'(inst_pc), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/branch_fetch_unit.md
Name: branch_fetch_unit

Overview:
- Instruction-fetch and PC sequencer; the producing end of the instruction stream consumed by the register-file/ALU/immediate-generator datapath.
- Owns the PC and issues one fetch at a time to instruction memory over a valid/ready request plus valid response.
- Presents each fetched instruction to the datapath with a valid/ready handshake.
- Accepts BEQ resolution (taken flag, branch PC, sign-extended immediate) back from the datapath and redirects fetch.

Parameters:
- PC_W, 16, PC and instruction-address width.
- INST_W, 32, instruction width.
- IMM_W, 64, width of the sign-extended immediate from the immediate generator.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  PC_W  fetch address, equal to the current PC.
- imem_rsp_valid  in  1  response data valid, one cycle.
- imem_rsp_data  in  INST_W  fetched instruction.
- inst_valid  out  1  instruction available to the datapath.
- inst_ready  in  1  datapath consumes the instruction.
- inst  out  INST_W  instruction to the datapath.
- inst_pc  out  PC_W  PC of the instruction on inst.
- br_valid  in  1  branch resolution valid, one cycle.
- br_taken  in  1  branch taken (ALU zero for BEQ).
- br_pc  in  PC_W  PC of the resolved branch.
- br_imm  in  IMM_W  sign-extended immediate, not yet shifted.
- redirect  out  1  one-cycle pulse when the PC is redirected.

Behaviour:
- Reset: clk and rst follow the codebase convention; rst is synchronous and active-high. On reset: PC = RESET_PC, state = IDLE, imem_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0, redirect = 0, discard flag = 0. Reset mid-transaction abandons the outstanding request; a late imem_rsp_valid in IDLE is ignored.
- IDLE: unconditionally moves to REQ on the next cycle.
- REQ: imem_req_valid = 1 and imem_addr = PC, both held stable until imem_req_ready. On imem_req_valid & imem_req_ready, move to WAIT.
- WAIT: on imem_rsp_valid:
  - If discard = 1: drop the data, clear discard, move to REQ.
  - Otherwise: capture inst = imem_rsp_data and inst_pc = PC, then move to HOLD.
- HOLD: inst_valid = 1, with inst and inst_pc held stable. On inst_valid & inst_ready: PC <= PC + 4 (mod 2^PC_W), inst_valid <= 0, move to REQ.
- Minimum issue-to-issue latency is 3 cycles (REQ, WAIT, HOLD) with zero-wait memory and inst_ready tied high.
- Branch target: br_pc + (br_imm[PC_W-1:0] << 1), truncated to PC_W bits with wrap-around. Bits [1:0] of the target are forced to 0.
- br_valid & !br_taken: no effect.
- br_valid & br_taken, any non-IDLE state. Takes priority over every same-cycle event. Effects next cycle:
  - PC = target; redirect = 1 for exactly one cycle; inst_valid = 0.
  - From HOLD or REQ: move to REQ with the new address. A REQ handshake occurring in the same cycle is treated as issued, so the unit goes to WAIT with discard = 1.
  - From WAIT: if imem_rsp_valid is high the same cycle, drop the data and move to REQ. Otherwise stay in WAIT with discard = 1.
  - A simultaneous inst_ready handshake is consumed, but PC = target, not PC + 4.
- br_valid in IDLE: ignored.
- Exactly one outstanding memory request at any time.

Optional Feature:
- Macro FETCH_REDIRECT_COUNT_EN.
- Defined: adds output redirect_cnt, 16 bits. Reset to 0; increments on every redirect pulse; saturates at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (IDLE, REQ, WAIT, HOLD);
  - the constants PC_STEP = 4 and RESET_PC default;
  - a branch-resolution struct {valid, taken, pc, imm}.
- One natural sub-module, branch_target_calc: combinational shift, add, truncate and alignment mask. Reused later by JAL support.

Test Plan:
- Reset, then zero-wait memory with inst_ready = 1 -> imem_addr sequence 0, 4, 8, 12; one issue every 3 cycles; redirect never asserted.
- inst_ready low for 5 cycles in HOLD -> inst and inst_pc stable; no new request; PC advances only after the handshake.
- br_valid = 1, br_taken = 1, br_pc = 8, br_imm = 6 in HOLD -> next cycle redirect = 1, inst_valid = 0, next imem_addr = 20. Same with br_taken = 0 -> no change.
- Taken branch while in WAIT with the response arriving 2 cycles later -> that response is dropped (inst_valid stays 0); next request address = target.
- br_pc = 16'hFFF0, br_imm = 16 -> target wraps to 16'h0010. br_imm = -2 sign-extended, br_pc = 8 -> target 4.
- With FETCH_REDIRECT_COUNT_EN: 3 taken branches -> redirect_cnt = 3. rst mid-WAIT -> counter 0, PC = RESET_PC, late response ignored.
